pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter BOOT_CYCLES, default 2, number of cycles fetch stays invalid after reset release (range 1-15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port stall  input  1  hazard-unit hold of IF and ID.
REQ-006 SHALL have port branch_d  input  1  ID-stage conditional branch.
REQ-007 SHALL have port equal_d  input  1  ID-stage branch compare result (1 = taken).
REQ-008 SHALL have port jump_d  input  1  ID-stage unconditional jump.
REQ-009 SHALL have port bdst  input  32  branch target from the branch adder.
REQ-010 SHALL have port jdst  input  32  jump target.
REQ-011 SHALL have port pc  output  32  current fetch address.
REQ-012 SHALL have port pc_4  output  32  pc + 4, combinational, feeds branch adder.
REQ-013 SHALL have port fetch_valid  output  1  fetch at pc is architecturally live.
REQ-014 SHALL have port flush_if  output  1  kill IF/ID register contents this edge.
REQ-015 SHALL have port align_err  output  1  sticky misaligned-target error.

Function
REQ-016 SHALL implement states BOOT, RUN, HALT; rst forces BOOT.
REQ-017 BOOT SHALL hold pc = RESET_PC, fetch_valid = 0, flush_if = 0, counting BOOT_CYCLES cycles, then enter RUN.
REQ-018 RUN next-pc priority SHALL be: stall (hold pc) > jump_d (jdst) > branch_d & equal_d (bdst) > pc_4.
REQ-019 Redirect (jump or taken branch) with stall = 0 SHALL load target into pc on the next edge and assert flush_if for exactly that same cycle (1-cycle penalty).
REQ-020 With stall = 1, branch_d/jump_d SHALL be ignored, pc held, flush_if = 0; redirect taken when instruction re-presented unstalled.
REQ-021 Redirect target with bits [1:0] != 0 SHALL not load pc; SHALL enter HALT, set align_err, assert flush_if that cycle.
REQ-022 HALT SHALL hold pc, fetch_valid = 0, flush_if = 0, align_err = 1 until rst.
REQ-023 pc arithmetic SHALL be 32-bit modulo; pc 32'hFFFF_FFFC advances to 32'h0000_0000 with no error.
REQ-024 fetch_valid SHALL be 1 in RUN, 0 in BOOT and HALT.
REQ-025 branch_d and jump_d both high SHALL resolve as jump.

Reset
REQ-026 On rst: pc = RESET_PC, state = BOOT, boot counter = 0, fetch_valid = 0, flush_if = 0, align_err = 0, perf counters (if compiled) = 0.
REQ-027 rst mid-operation (any state, incl. during redirect or stall) SHALL take effect on that edge, overriding all inputs.

Configuration
REQ-028 Macro PC_SEQ_PERF_EN SHALL add outputs br_cnt (32) and br_taken_cnt (32): unstalled RUN cycles with branch_d high, and those also taken; wrap modulo 2^32.
REQ-029 Without PC_SEQ_PERF_EN these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 State encoding, BOOT_CYCLES width constant and 32-bit instruction-step constant (4) SHALL live in shared package pipe_pkg.
REQ-031 Perf counters SHALL be one sub-module, pc_seq_perf, instantiated only under PC_SEQ_PERF_EN; next-pc mux remains inline.

Verification
REQ-032 rst 1 cycle, RESET_PC=0x100, BOOT_CYCLES=2 -> pc 0x100, fetch_valid 0 for 2 cycles, then pc 0x100,0x104,0x108 with fetch_valid 1.
REQ-033 pc=0x200, branch_d=1, equal_d=1, bdst=0x300 -> flush_if=1 that cycle, next pc 0x300; equal_d=0 -> pc 0x204, flush_if 0.
REQ-034 pc=0x200, stall=1, jump_d=1, jdst=0x400 for 2 cycles, then stall=0 -> pc held 0x200 twice, then 0x400 with single flush_if pulse.
REQ-035 jump_d=1, jdst=0x402 -> align_err=1, state HALT, pc unchanged, fetch_valid 0; stays until rst, rst clears align_err.
REQ-036 pc=0xFFFF_FFFC, no redirect -> next pc 0x0000_0000, align_err 0; with PC_SEQ_PERF_EN, 3 branches (2 taken) -> br_cnt=3, br_taken_cnt=2.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared sequencer state encoding and fetch constants
package pipe_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} seq_state_t;
  localparam int BOOT_CNT_W = 4;
  localparam logic [31:0] INSTR_STEP = 32'd4;
endpackage

// File: rtl/pc_seq_perf.sv
// pc_seq_perf: wrapping counters of issued and taken branches
module pc_seq_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_ev,
  input  logic        taken_ev,
  output logic [31:0] br_cnt,
  output logic [31:0] br_taken_cnt
);
  // count branch events, both counters wrap modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt <= '0;
      br_taken_cnt <= '0;
    end else begin
      br_cnt <= br_cnt + {31'd0, br_ev};
      br_taken_cnt <= br_taken_cnt + {31'd0, taken_ev};
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch pc sequencing with boot delay, redirects and alignment halt (optional PC_SEQ_PERF_EN branch counters)
module pc_sequencer
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_d,
  input  logic        equal_d,
  input  logic        jump_d,
  input  logic [31:0] bdst,
  input  logic [31:0] jdst,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        fetch_valid,
  output logic        flush_if,
`ifdef PC_SEQ_PERF_EN
  output logic [31:0] br_cnt,
  output logic [31:0] br_taken_cnt,
`endif
  output logic        align_err
);
  seq_state_t state, state_n;
  logic [BOOT_CNT_W-1:0] cnt, cnt_n;
  logic [31:0] pc_n, tgt;
  logic err_n, redirect, mis;
  assign pc_4 = pc + INSTR_STEP;
  assign fetch_valid = state == RUN;
  assign redirect = !stall && (jump_d || (branch_d && equal_d));
  assign tgt = jump_d ? jdst : bdst;
  assign mis = tgt[1:0] != 2'b00;
  // state, pc, boot counter and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
      pc <= RESET_PC;
      cnt <= '0;
      align_err <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      cnt <= cnt_n;
      align_err <= err_n;
    end
  end
  // next-state and next-pc selection; misaligned redirect halts instead of loading
  always_comb begin
    state_n = state;
    pc_n = pc;
    cnt_n = cnt;
    err_n = align_err;
    flush_if = 1'b0;
    case (state)
      BOOT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == BOOT_CNT_W'(BOOT_CYCLES - 1)) begin
          state_n = RUN;
          cnt_n = '0;
        end
      end
      RUN: begin
        flush_if = redirect;
        if (redirect && mis) begin
          state_n = HALT;
          err_n = 1'b1;
        end else begin
          pc_n = stall ? pc : redirect ? tgt : pc_4;
        end
      end
      HALT: ;
      default: state_n = BOOT;
    endcase
  end
`ifdef PC_SEQ_PERF_EN
  pc_seq_perf u_perf (
    .clk(clk),
    .rst(rst),
    .br_ev(fetch_valid && !stall && branch_d),
    .taken_ev(fetch_valid && !stall && branch_d && equal_d),
    .br_cnt(br_cnt),
    .br_taken_cnt(br_taken_cnt)
  );
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed table-driven check of pc_sequencer
module tb_pc_sequencer;
  logic clk, rst, stall, branch_d, equal_d, jump_d;
  logic [31:0] bdst, jdst, pc, pc_4;
  logic fetch_valid, flush_if, align_err;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] br_cnt, br_taken_cnt;
`endif
  int n_cmp = 0;
  int n_err = 0;

  pc_sequencer #(.RESET_PC(32'h100), .BOOT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_d(branch_d), .equal_d(equal_d),
    .jump_d(jump_d), .bdst(bdst), .jdst(jdst), .pc(pc), .pc_4(pc_4),
    .fetch_valid(fetch_valid), .flush_if(flush_if),
`ifdef PC_SEQ_PERF_EN
    .br_cnt(br_cnt), .br_taken_cnt(br_taken_cnt),
`endif
    .align_err(align_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic st, br, eq, jp;
    logic [31:0] bd, jd;
    logic [31:0] e_pc;
    logic e_fl, e_v, e_err;
  } vec_t;

  vec_t tbl[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic eq, input logic jp,
                       input logic [31:0] bd, input logic [31:0] jd);
    stall = st; branch_d = br; equal_d = eq; jump_d = jp; bdst = bd; jdst = jd;
  endtask

  task automatic outs(input string tag, input logic [31:0] e_pc, input logic e_fl,
                      input logic e_v, input logic e_err);
    check({tag, " pc"}, pc, e_pc);
    check({tag, " pc_4"}, pc_4, e_pc + 32'd4);
    check({tag, " flush_if"}, {31'd0, flush_if}, {31'd0, e_fl});
    check({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e_v});
    check({tag, " align_err"}, {31'd0, align_err}, {31'd0, e_err});
  endtask

  task automatic rst_pulse();
    rst = 1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    //           st br eq jp  bdst           jdst           pc             fl v  err
    tbl[0]  = '{0, 0, 0, 1, 32'h0,         32'h500,       32'h100,       0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h100,       0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h100,       0, 1, 0};
    tbl[3]  = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h104,       0, 1, 0};
    tbl[4]  = '{0, 0, 0, 1, 32'h0,         32'h200,       32'h108,       1, 1, 0};
    tbl[5]  = '{0, 1, 1, 0, 32'h300,       32'h0,         32'h200,       1, 1, 0};
    tbl[6]  = '{0, 0, 0, 1, 32'h0,         32'h200,       32'h300,       1, 1, 0};
    tbl[7]  = '{0, 1, 0, 0, 32'h300,       32'h0,         32'h200,       0, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h204,       0, 1, 0};
    tbl[9]  = '{1, 0, 0, 1, 32'h0,         32'h400,       32'h208,       0, 1, 0};
    tbl[10] = '{1, 0, 0, 1, 32'h0,         32'h400,       32'h208,       0, 1, 0};
    tbl[11] = '{0, 0, 0, 1, 32'h0,         32'h400,       32'h208,       1, 1, 0};
    tbl[12] = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h400,       0, 1, 0};
    tbl[13] = '{0, 1, 1, 1, 32'h600,       32'h700,       32'h404,       1, 1, 0};
    tbl[14] = '{1, 0, 0, 0, 32'h0,         32'h0,         32'h700,       0, 1, 0};
    tbl[15] = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h700,       0, 1, 0};
    tbl[16] = '{1, 1, 1, 0, 32'h801,       32'h0,         32'h704,       0, 1, 0};
    tbl[17] = '{0, 0, 0, 1, 32'h0,         32'hFFFF_FFFC, 32'h704,       1, 1, 0};
    tbl[18] = '{0, 0, 0, 0, 32'h0,         32'h0,         32'hFFFF_FFFC, 0, 1, 0};
    tbl[19] = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0, 1, 0};
    tbl[20] = '{0, 0, 0, 1, 32'h0,         32'h402,       32'h4,         1, 1, 0};
    tbl[21] = '{0, 0, 0, 0, 32'h0,         32'h0,         32'h4,         0, 0, 1};
    tbl[22] = '{0, 0, 0, 1, 32'h0,         32'h800,       32'h4,         0, 0, 1};
    tbl[23] = '{0, 1, 1, 0, 32'h900,       32'h0,         32'h4,         0, 0, 1};

    rst = 1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].st, tbl[i].br, tbl[i].eq, tbl[i].jp, tbl[i].bd, tbl[i].jd);
      #1;
      outs($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_fl, tbl[i].e_v, tbl[i].e_err);
      @(negedge clk);
    end
`ifdef PC_SEQ_PERF_EN
    check("br_cnt", br_cnt, 32'd3);
    check("br_taken_cnt", br_taken_cnt, 32'd2);
`endif

    rst_pulse();
    #1;
    outs("halt_rst", 32'h100, 0, 0, 0);
`ifdef PC_SEQ_PERF_EN
    check("br_cnt_rst", br_cnt, 32'd0);
    check("br_taken_cnt_rst", br_taken_cnt, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    #1;
    outs("run_again", 32'h100, 0, 1, 0);

    drive(0, 0, 0, 1, 32'h0, 32'h200);
    rst = 1;
    @(negedge clk);
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    outs("rst_over_jump", 32'h100, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    outs("seq_104", 32'h104, 0, 1, 0);

    drive(1, 0, 0, 0, 0, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    outs("rst_over_stall", 32'h100, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1, 1, 0, 32'h302, 32'h0);
    #1;
    outs("br_mis", 32'h100, 1, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    outs("br_mis_halt", 32'h100, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
